// File: rtl/bcd_seq_conv_pkg.sv
// Shared display-path definitions: converter state encoding, BCD nibble width,
// and the decimal-digit sizing check used when the converter is elaborated.
package bcd_seq_conv_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed to show 2^width-1; DIGITS must be at least this.
    function automatic int unsigned bcd_digits_needed(input int unsigned width);
        logic [127:0] v;
        int unsigned  n;
        v = (128'd1 << width) - 128'd1;
        n = 0;
        do begin
            v = v / 128'd10;
            n++;
        end while (v != 128'd0);
        return n;
    endfunction

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Start/busy/done handshake and data bus between the datapath and the BCD converter.
// The converter has no backpressure: start while busy is simply ignored.
interface bcd_seq_conv_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bcd_seq_conv_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
// Purely combinational, zero latency.
module bcd_add3
    import bcd_seq_conv_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter; result valid WIDTH+1 cycles after start.
// start is ignored while busy; bcd holds the last result until the next conversion completes.
module bcd_seq_conv
    import bcd_seq_conv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst,
    bcd_seq_conv_if.slave io
);
    localparam int BW    = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (DIGITS < int'(bcd_digits_needed(WIDTH))) begin : g_digits_check
            $error("bcd_seq_conv: DIGITS too small to hold 2^WIDTH-1");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    scr_q, scr_d, scr_fix;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_i (scr_q[g*BCD_W +: BCD_W]),
                .digit_o (scr_fix[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    sh_d    = io.bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Corrected digits and the binary remainder shift as one word.
                {scr_d, sh_d} = {scr_fix, sh_q} << 1;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign io.busy = (state_q != IDLE);
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: a 16-bit/5-digit and an 8-bit/3-digit instance side by side.
module tb_bcd_seq_conv;
    localparam int W_A [2] = '{16, 8};
    localparam int D_A [2] = '{5, 3};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a [2];
    logic [31:0] bin_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic [31:0] bcd_a   [2];

    int vectors     = 0;
    int miscompares = 0;

    bcd_seq_conv_if #(.WIDTH(16), .DIGITS(5)) if0 ();
    bcd_seq_conv_if #(.WIDTH(8),  .DIGITS(3)) if1 ();

    bcd_seq_conv #(.WIDTH(16), .DIGITS(5)) u_dut0 (.clk(clk), .rst(rst), .io(if0.slave));
    bcd_seq_conv #(.WIDTH(8),  .DIGITS(3)) u_dut1 (.clk(clk), .rst(rst), .io(if1.slave));

    assign if0.start = start_a[0];
    assign if0.bin   = bin_a[0][15:0];
    assign if1.start = start_a[1];
    assign if1.bin   = bin_a[1][7:0];
    assign busy_a[0] = if0.busy;
    assign done_a[0] = if0.done;
    assign bcd_a[0]  = {12'd0, if0.bcd};
    assign busy_a[1] = if1.busy;
    assign done_a[1] = if1.done;
    assign bcd_a[1]  = {20'd0, if1.bcd};

    // Reference: decimal digits by repeated division.
    function automatic logic [31:0] to_bcd(input int unsigned v, input int d);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Timing model: a conversion occupies WIDTH+1 cycles, then the result appears with done.
    int          rem      [2];
    logic [31:0] pend     [2];
    logic [31:0] exp_bcd  [2];
    logic        exp_done [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                rem[i]      <= 0;
                pend[i]     <= '0;
                exp_bcd[i]  <= '0;
                exp_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_done[i] <= 1'b0;
                if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        exp_bcd[i]  <= pend[i];
                        exp_done[i] <= 1'b1;
                    end
                end else if (start_a[i]) begin
                    rem[i]  <= W_A[i] + 1;
                    pend[i] <= to_bcd(bin_a[i] & ((32'd1 << W_A[i]) - 32'd1), D_A[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (busy_a[i] !== (rem[i] > 0) || done_a[i] !== exp_done[i] ||
                    bcd_a[i] !== exp_bcd[i]) begin
                    miscompares++;
                    $display("FAIL model dut%0d t=%0t: got busy=%0b done=%0b bcd=%h, want busy=%0b done=%0b bcd=%h",
                             i, $time, busy_a[i], done_a[i], bcd_a[i], rem[i] > 0, exp_done[i], exp_bcd[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp_v);
        end
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 40 && busy_a[i]; c++) tick();
        if (busy_a[i]) check("wait_idle timeout", 32'(busy_a[i]), 32'd0);
    endtask

    task automatic run_conv(input int i, input logic [31:0] v, input logic [31:0] lit, input string nm);
        int n;
        bit got;
        wait_idle(i);
        start_a[i] = 1'b1;
        bin_a[i]   = v;
        tick();
        start_a[i] = 1'b0;
        check({nm, " busy"}, 32'(busy_a[i]), 32'd1);
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            n++;
            if (done_a[i]) got = 1'b1;
        end
        check({nm, " latency"}, 32'(n), 32'(W_A[i] + 1));
        check({nm, " bcd"}, bcd_a[i], lit);
    endtask

    initial begin
        int pulses, d1, d2, n;
        start_a[0] = 1'b0; start_a[1] = 1'b0;
        bin_a[0]   = '0;   bin_a[1]   = '0;
        #1;
        check("reset bcd0", bcd_a[0], 32'h0);
        check("reset busy0", 32'(busy_a[0]), 32'd0);
        check("reset done0", 32'(done_a[0]), 32'd0);
        check("reset bcd1", bcd_a[1], 32'h0);
        tick(); tick();
        rst = 1'b1;

        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done_a[0] || done_a[1]) pulses++;
        end
        check("idle done pulses", 32'(pulses), 32'd0);
        check("idle bcd", bcd_a[0], 32'h0);
        check("idle busy", 32'(busy_a[0]), 32'd0);

        run_conv(0, 32'd0,     32'h00000, "bin0");
        run_conv(0, 32'd1234,  32'h01234, "bin1234");
        run_conv(0, 32'd65535, 32'h65535, "bin65535");

        // start during a conversion must be dropped
        wait_idle(0);
        start_a[0] = 1'b1; bin_a[0] = 32'd4321;
        tick();
        start_a[0] = 1'b0;
        repeat (4) tick();
        start_a[0] = 1'b1; bin_a[0] = 32'd9999;
        tick();
        start_a[0] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_a[0]) pulses++;
        end
        check("ignored start pulses", 32'(pulses), 32'd1);
        check("ignored start bcd", bcd_a[0], 32'h04321);

        // reset in the middle of a conversion
        start_a[0] = 1'b1; bin_a[0] = 32'd500;
        tick();
        start_a[0] = 1'b0;
        repeat (7) tick();
        rst = 1'b0;
        #1;
        check("midrst bcd", bcd_a[0], 32'h0);
        check("midrst busy", 32'(busy_a[0]), 32'd0);
        check("midrst done", 32'(done_a[0]), 32'd0);
        tick();
        rst = 1'b1;
        run_conv(0, 32'd7, 32'h00007, "after reset");

        // start held high: back-to-back conversions
        wait_idle(0);
        start_a[0] = 1'b1; bin_a[0] = 32'd100;
        tick();
        bin_a[0] = 32'd200;
        n = 0; d1 = -1; d2 = -1;
        for (int c = 0; c < 60 && d2 < 0; c++) begin
            tick();
            n++;
            if (done_a[0]) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b first bcd", bcd_a[0], 32'h00100);
                end else begin
                    d2 = n;
                    start_a[0] = 1'b0;
                    check("b2b second bcd", bcd_a[0], 32'h00200);
                end
            end else if (d1 >= 0) begin
                check("b2b hold bcd", bcd_a[0], 32'h00100);
            end
        end
        start_a[0] = 1'b0;
        check("b2b first latency", 32'(d1), 32'd17);
        check("b2b spacing", 32'(d2 - d1), 32'd18);

        // 8-bit / 3-digit instance
        run_conv(1, 32'd255, 32'h255, "w8 255");
        for (int v = 0; v < 256; v++) run_conv(1, 32'(v), to_bcd(v, 3), "w8 sweep");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
